// File: rtl/mem_alloc_arbiter.sv
// ---------------------------------------------------------------------------
// mem_alloc_arbiter
//   Shares one mem_manager between NPORT input-port writers.
//   Allocate path: round-robin arbitration of per-port block-allocate requests
//   onto the single mm_ocp_req/mm_ocp_rsp handshake, followed by a settle gap
//   so mem_manager always sees its request drop while its bitmap updates.
//   Release path: round-robin merge of per-port block releases onto the single
//   mm_rls_vld/mm_rls_addr port, at most one release per cycle, independent of
//   the allocate FSM.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   alc_req         per-port allocate request (level, held until alc_gnt)
//   alc_gnt         one-hot 1-cycle grant pulse
//   alc_addr        allocated block address, valid while alc_gnt != 0
//   rls_req         per-port release request (level, held until rls_ack)
//   rls_addr        packed release addresses, port i at [i*AWIDTH +: AWIDTH]
//   rls_ack         one-hot 1-cycle release-forwarded pulse
//   mm_ocp_req      allocate request to mem_manager
//   mm_ocp_rsp/vld  allocate response / address-valid from mem_manager
//   mm_ocp_addr     allocated block address from mem_manager
//   mm_full         mem_manager has no free block
//   mm_rls_vld      release strobe to mem_manager
//   mm_rls_addr     released block address to mem_manager
//   alc_busy        allocate FSM is not idle
//   alc_owner       port currently being served (valid while alc_busy)
// All outputs are registered.
// ---------------------------------------------------------------------------
module mem_alloc_arbiter #(
    parameter int NPORT   = 4,
    parameter int AWIDTH  = 10,
    parameter int PWIDTH  = 2,
    parameter int GAP_CYC = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NPORT-1:0]        alc_req,
    output logic [NPORT-1:0]        alc_gnt,
    output logic [AWIDTH-1:0]       alc_addr,
    input  logic [NPORT-1:0]        rls_req,
    input  logic [NPORT*AWIDTH-1:0] rls_addr,
    output logic [NPORT-1:0]        rls_ack,
    output logic                    mm_ocp_req,
    input  logic                    mm_ocp_rsp,
    input  logic                    mm_ocp_vld,
    input  logic [AWIDTH-1:0]       mm_ocp_addr,
    input  logic                    mm_full,
    output logic                    mm_rls_vld,
    output logic [AWIDTH-1:0]       mm_rls_addr,
    output logic                    alc_busy,
    output logic [PWIDTH-1:0]       alc_owner
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [PWIDTH-1:0]   alc_ptr, alc_ptr_nxt;
    logic [PWIDTH-1:0]   alc_owner_nxt;
    logic [2:0]          gap_cnt, gap_cnt_nxt;
    logic                mm_ocp_req_nxt;
    logic                alc_busy_nxt;
    logic [NPORT-1:0]    alc_gnt_nxt;
    logic [AWIDTH-1:0]   alc_addr_nxt;

    logic [PWIDTH-1:0]   rls_ptr, rls_ptr_nxt;
    logic [NPORT-1:0]    rls_elig;
    logic [PWIDTH-1:0]   rls_win;
    logic [NPORT-1:0]    rls_ack_nxt;
    logic                mm_rls_vld_nxt;
    logic [AWIDTH-1:0]   mm_rls_addr_nxt;

    // First set bit of req at or after ptr, scanning upward with wrap.
    function automatic logic [PWIDTH-1:0] rr_pick(input logic [NPORT-1:0]  req,
                                                  input logic [PWIDTH-1:0] ptr);
        logic [PWIDTH-1:0] pick;
        logic              found;
        int                idx;
        pick  = ptr;
        found = 1'b0;
        for (int k = 0; k < NPORT; k++) begin
            idx = (int'(ptr) + k) % NPORT;
            if (!found && req[idx]) begin
                pick  = PWIDTH'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // Pointer advance modulo NPORT (correct for non-power-of-2 NPORT too).
    function automatic logic [PWIDTH-1:0] ptr_inc(input logic [PWIDTH-1:0] p);
        return (int'(p) == NPORT - 1) ? '0 : p + PWIDTH'(1);
    endfunction

    // ---------------- allocate FSM: next state / next outputs ----------------
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned; otherwise synthesis infers a latch.
        state_nxt      = state;
        alc_ptr_nxt    = alc_ptr;
        alc_owner_nxt  = alc_owner;
        gap_cnt_nxt    = gap_cnt;
        mm_ocp_req_nxt = mm_ocp_req;
        alc_gnt_nxt    = '0;          // grant and address are single-cycle pulses
        alc_addr_nxt   = '0;

        case (state)
            S_IDLE: begin
                // A full mem_manager holds requests off; they stay pending.
                if (|alc_req && !mm_full) begin
                    alc_owner_nxt  = rr_pick(alc_req, alc_ptr);
                    mm_ocp_req_nxt = 1'b1;
                    state_nxt      = S_REQ;
                end
            end
            S_REQ: begin
                // mm_full changes are ignored here: mem_manager has committed.
                mm_ocp_req_nxt = 1'b1;
                if (mm_ocp_rsp && mm_ocp_vld) begin
                    mm_ocp_req_nxt          = 1'b0;
                    alc_gnt_nxt[alc_owner]  = 1'b1;
                    alc_addr_nxt            = mm_ocp_addr;
                    alc_ptr_nxt             = ptr_inc(alc_owner);
                    gap_cnt_nxt             = 3'(GAP_CYC);
                    state_nxt               = S_GAP;
                end
            end
            S_GAP: begin
                // Settle time so mem_manager observes req low before the next one.
                if (gap_cnt == 3'd0) begin
                    state_nxt = S_IDLE;
                end else begin
                    gap_cnt_nxt = gap_cnt - 3'd1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        alc_busy_nxt = (state_nxt != S_IDLE);
    end

    // ---------------- release merge: next outputs ----------------
    always_comb begin
        // A port acked last cycle still shows its request high; mask it so the
        // same release is not forwarded twice.
        rls_elig        = rls_req & ~rls_ack;
        rls_win         = rr_pick(rls_elig, rls_ptr);
        rls_ptr_nxt     = rls_ptr;
        rls_ack_nxt     = '0;
        mm_rls_vld_nxt  = 1'b0;
        mm_rls_addr_nxt = '0;
        if (|rls_elig) begin
            rls_ack_nxt[rls_win] = 1'b1;
            mm_rls_vld_nxt       = 1'b1;
            mm_rls_addr_nxt      = rls_addr[int'(rls_win)*AWIDTH +: AWIDTH];
            rls_ptr_nxt          = ptr_inc(rls_win);
        end
    end

    // ---------------- registers ----------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            alc_ptr     <= '0;
            alc_owner   <= '0;
            gap_cnt     <= '0;
            mm_ocp_req  <= 1'b0;
            alc_busy    <= 1'b0;
            alc_gnt     <= '0;
            alc_addr    <= '0;
            rls_ptr     <= '0;
            rls_ack     <= '0;
            mm_rls_vld  <= 1'b0;
            mm_rls_addr <= '0;
        end else begin
            state       <= state_nxt;
            alc_ptr     <= alc_ptr_nxt;
            alc_owner   <= alc_owner_nxt;
            gap_cnt     <= gap_cnt_nxt;
            mm_ocp_req  <= mm_ocp_req_nxt;
            alc_busy    <= alc_busy_nxt;
            alc_gnt     <= alc_gnt_nxt;
            alc_addr    <= alc_addr_nxt;
            rls_ptr     <= rls_ptr_nxt;
            rls_ack     <= rls_ack_nxt;
            mm_rls_vld  <= mm_rls_vld_nxt;
            mm_rls_addr <= mm_rls_addr_nxt;
        end
    end

endmodule

// File: tb/tb_mem_alloc_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_alloc_arbiter
//   Directed testbench for mem_alloc_arbiter (NPORT=4, AWIDTH=10, GAP_CYC=2).
//   The bench plays the role of mem_manager and of the per-port controllers.
//   Outputs are sampled 1 time unit after the rising clock edge.
// ---------------------------------------------------------------------------
module tb_mem_alloc_arbiter;

    localparam int NPORT   = 4;
    localparam int AWIDTH  = 10;
    localparam int PWIDTH  = 2;
    localparam int GAP_CYC = 2;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NPORT-1:0]        alc_req;
    logic [NPORT-1:0]        alc_gnt;
    logic [AWIDTH-1:0]       alc_addr;
    logic [NPORT-1:0]        rls_req;
    logic [NPORT*AWIDTH-1:0] rls_addr;
    logic [NPORT-1:0]        rls_ack;
    logic                    mm_ocp_req;
    logic                    mm_ocp_rsp;
    logic                    mm_ocp_vld;
    logic [AWIDTH-1:0]       mm_ocp_addr;
    logic                    mm_full;
    logic                    mm_rls_vld;
    logic [AWIDTH-1:0]       mm_rls_addr;
    logic                    alc_busy;
    logic [PWIDTH-1:0]       alc_owner;

    int n_checks  = 0;
    int n_err     = 0;
    int req_cyc   = 0;   // clock edges seen with mm_ocp_req high
    int gnt_total = 0;   // clock edges seen with any alc_gnt bit high
    int waited;
    int snap_req;
    int snap_gnt;

    logic [3:0]        t4_ack  [3] = '{4'b0001, 4'b0010, 4'b1000};
    logic [AWIDTH-1:0] t4_addr [3] = '{10'h010, 10'h011, 10'h013};
    logic [3:0]        exp_gnt;

    mem_alloc_arbiter #(
        .NPORT  (NPORT),
        .AWIDTH (AWIDTH),
        .PWIDTH (PWIDTH),
        .GAP_CYC(GAP_CYC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .alc_req    (alc_req),
        .alc_gnt    (alc_gnt),
        .alc_addr   (alc_addr),
        .rls_req    (rls_req),
        .rls_addr   (rls_addr),
        .rls_ack    (rls_ack),
        .mm_ocp_req (mm_ocp_req),
        .mm_ocp_rsp (mm_ocp_rsp),
        .mm_ocp_vld (mm_ocp_vld),
        .mm_ocp_addr(mm_ocp_addr),
        .mm_full    (mm_full),
        .mm_rls_vld (mm_rls_vld),
        .mm_rls_addr(mm_rls_addr),
        .alc_busy   (alc_busy),
        .alc_owner  (alc_owner)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mm_ocp_req) req_cyc++;
        if (|alc_gnt)   gnt_total++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance until mm_ocp_req is seen high (bounded); returns cycles waited.
    task automatic wait_req(output int w);
        w = 0;
        do begin
            step();
            w++;
        end while (!mm_ocp_req && w < 50);
        check("req_seen", mm_ocp_req, 1);
    endtask

    // mem_manager response: rsp/vld asserted after 'dly' further cycles,
    // held for one edge, then removed. Returns at the sample after that edge.
    task automatic respond(input int dly, input logic [AWIDTH-1:0] a);
        repeat (dly) step();
        mm_ocp_rsp  = 1'b1;
        mm_ocp_vld  = 1'b1;
        mm_ocp_addr = a;
        step();
        mm_ocp_rsp  = 1'b0;
        mm_ocp_vld  = 1'b0;
        mm_ocp_addr = '0;
    endtask

    initial begin
        rst         = 1'b1;
        alc_req     = '0;
        rls_req     = '0;
        rls_addr    = '0;
        mm_ocp_rsp  = 1'b0;
        mm_ocp_vld  = 1'b0;
        mm_ocp_addr = '0;
        mm_full     = 1'b0;
        repeat (2) step();

        // ---- reset state ----
        check("rst_ocp_req",  mm_ocp_req,  0);
        check("rst_alc_gnt",  alc_gnt,     0);
        check("rst_alc_addr", alc_addr,    0);
        check("rst_rls_ack",  rls_ack,     0);
        check("rst_rls_vld",  mm_rls_vld,  0);
        check("rst_rls_addr", mm_rls_addr, 0);
        check("rst_busy",     alc_busy,    0);
        check("rst_owner",    alc_owner,   0);
        rst = 1'b0;
        step();

        // ---- T1: single request, response 3 cycles after req seen ----
        alc_req = 4'b0001;
        wait_req(waited);
        check("t1_req_latency", waited, 1);
        check("t1_busy",  alc_busy,  1);
        check("t1_owner", alc_owner, 0);
        snap_req = req_cyc;
        respond(3, 10'h005);
        alc_req = '0;
        check("t1_gnt",       alc_gnt,    4'b0001);
        check("t1_addr",      alc_addr,   10'h005);
        check("t1_req_drop",  mm_ocp_req, 0);
        check("t1_req_cycles", req_cyc - snap_req, 4);
        step();
        check("t1_gnt_pulse",  alc_gnt,  0);
        check("t1_addr_clear", alc_addr, 0);
        repeat (4) step();
        check("t1_idle", alc_busy, 0);

        rst = 1'b1;
        step();
        rst = 1'b0;

        // ---- T2: all ports requesting, grants rotate 0,1,2,3,0 ----
        alc_req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_req(waited);
            if (i > 0) check("t2_spacing", waited, GAP_CYC + 2);
            check("t2_owner", alc_owner, i % 4);
            respond(0, AWIDTH'(10'h100 + i));
            if (i == 4) alc_req = '0;
            exp_gnt = 4'b0001 << (i % 4);
            check("t2_gnt",  alc_gnt,  exp_gnt);
            check("t2_addr", alc_addr, 10'h100 + i);
        end
        repeat (5) step();

        // ---- T3: mm_full holds the request off, then grant port 2 ----
        mm_full  = 1'b1;
        alc_req  = 4'b0100;
        snap_req = req_cyc;
        snap_gnt = gnt_total;
        repeat (6) step();
        check("t3_no_req",  req_cyc - snap_req,   0);
        check("t3_no_gnt",  gnt_total - snap_gnt, 0);
        check("t3_idle",    alc_busy,             0);
        mm_full = 1'b0;
        wait_req(waited);
        check("t3_req_latency", waited, 1);
        check("t3_owner", alc_owner, 2);
        respond(1, 10'h0AB);
        alc_req = '0;
        check("t3_gnt",  alc_gnt,  4'b0100);
        check("t3_addr", alc_addr, 10'h0AB);
        repeat (5) step();

        // ---- T4: ports 0,1,3 release together ----
        rls_addr = {10'h013, 10'h000, 10'h011, 10'h010};
        rls_req  = 4'b1011;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t4_vld",  mm_rls_vld,  1);
            check("t4_addr", mm_rls_addr, t4_addr[i]);
            check("t4_ack",  rls_ack,     t4_ack[i]);
            rls_req = rls_req & ~rls_ack;
        end
        step();
        check("t4_vld_end",  mm_rls_vld,  0);
        check("t4_ack_end",  rls_ack,     0);
        check("t4_addr_end", mm_rls_addr, 0);

        // ---- T5: allocate grant and release ack on port 1 in the same cycle ----
        alc_req = 4'b0010;
        wait_req(waited);
        check("t5_owner", alc_owner, 1);
        rls_addr[1*AWIDTH +: AWIDTH] = 10'h020;
        rls_req = 4'b0010;
        respond(0, 10'h0CD);
        check("t5_gnt",      alc_gnt,     4'b0010);
        check("t5_alc_addr", alc_addr,    10'h0CD);
        check("t5_rls_ack",  rls_ack,     4'b0010);
        check("t5_rls_vld",  mm_rls_vld,  1);
        check("t5_rls_addr", mm_rls_addr, 10'h020);
        rls_req = '0;
        alc_req = '0;
        step();
        check("t5_ack_pulse", rls_ack, 0);
        repeat (4) step();

        // ---- T6: reset asserted while in REQ ----
        alc_req = 4'b0100;
        wait_req(waited);
        check("t6_busy_pre",  alc_busy,  1);
        check("t6_owner_pre", alc_owner, 2);
        #2;
        rst = 1'b1;
        #1;
        check("t6_rst_ocp_req", mm_ocp_req, 0);
        check("t6_rst_busy",    alc_busy,   0);
        check("t6_rst_owner",   alc_owner,  0);
        check("t6_rst_gnt",     alc_gnt,    0);
        check("t6_rst_rls_vld", mm_rls_vld, 0);
        alc_req  = 4'b1111;
        rls_req  = 4'b1111;
        rls_addr = {10'h033, 10'h032, 10'h031, 10'h030};
        step();
        rst = 1'b0;
        step();
        check("t6_post_owner",    alc_owner,   0);
        check("t6_post_busy",     alc_busy,    1);
        check("t6_post_rls_ack",  rls_ack,     4'b0001);
        check("t6_post_rls_addr", mm_rls_addr, 10'h030);
        rls_req = '0;
        respond(0, 10'h3FF);
        alc_req = '0;
        check("t6_post_gnt",  alc_gnt,  4'b0001);
        check("t6_post_addr", alc_addr, 10'h3FF);
        repeat (5) step();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
